// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund greedily as 50/10/5/1 coins over a valid/ack eject
// handshake, skipping empty denominations, and reports the unpaid remainder.
module change_dispenser #(
    parameter int unsigned INIT_50 = 4,
    parameter int unsigned INIT_10 = 10,
    parameter int unsigned INIT_5  = 10,
    parameter int unsigned INIT_1  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [6:0] amount,
    output logic       ready,
    output logic       eject,
    output logic [1:0] eject_coin,
    input  logic       eject_ack,
    output logic       done,
    output logic [6:0] short,
    input  logic       refill,
    input  logic [1:0] refill_sel,
    input  logic [7:0] refill_cnt,
    output logic [3:0] stock_empty
);

    typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

    // Indexed by coin code: 0=1, 1=5, 2=10, 3=50.
    localparam logic [7:0] INIT_STOCK [4] = '{8'(INIT_1), 8'(INIT_5), 8'(INIT_10), 8'(INIT_50)};

    state_t     state, state_nxt;
    logic [6:0] remain;
    logic [7:0] stock [4];
    logic       pick_found;
    logic [1:0] pick_coin;
    logic [8:0] refill_sum;
    logic [7:0] refill_val;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    return 7'd1;
            2'd1:    return 7'd5;
            2'd2:    return 7'd10;
            default: return 7'd50;
        endcase
    endfunction

    // Ascending scan: the last hit is the largest payable, in-stock denomination.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pick_found = 1'b0;
        pick_coin  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (stock[i] != 8'd0 && coin_value(2'(i)) <= remain) begin
                pick_found = 1'b1;
                pick_coin  = 2'(i);
            end
        end
    end

    always_comb begin
        refill_sum = {1'b0, stock[refill_sel]} + {1'b0, refill_cnt};
        refill_val = refill_sum[8] ? 8'hFF : refill_sum[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SELECT;
            SELECT:  state_nxt = pick_found ? EJECT : DONE;
            EJECT:   if (eject_ack) state_nxt = SELECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        eject = (state == EJECT);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain     <= 7'd0;
            eject_coin <= 2'd0;
            short      <= 7'd0;
        end else begin
            case (state)
                IDLE:   if (req) remain <= amount;
                SELECT: begin
                    if (pick_found) eject_coin <= pick_coin;
                    else            short      <= remain;
                end
                EJECT:  if (eject_ack) remain <= remain - coin_value(eject_coin);
                default: ;
            endcase
        end
    end

    // NOTE: the stock counters are architectural state, so unlike a data buffer they must be reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) stock[i] <= INIT_STOCK[i];
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state == IDLE && refill && refill_sel == 2'(i))
                    stock[i] <= refill_val;
                else if (state == EJECT && eject_ack && eject_coin == 2'(i))
                    stock[i] <= stock[i] - 8'd1;
            end
        end
    end

    always_comb begin
        stock_empty = 4'b0000;
        for (int i = 0; i < 4; i++) stock_empty[i] = (stock[i] == 8'd0);
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return unit that pays out a refund amount as physical coins. It sits downstream of the vending controller's refund output. It accepts one refund request at a time and breaks the amount down greedily into 50/10/5/1 coins, skipping any denomination whose stock is empty. It hands coins to the eject mechanism one at a time over a valid/ack handshake, tracks per-denomination stock, and reports any amount it could not pay.

## Interface
- INIT_50, default 4: stock of 50-coins after reset
- INIT_10, default 10: stock of 10-coins after reset
- INIT_5, default 10: stock of 5-coins after reset
- INIT_1, default 20: stock of 1-coins after reset
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low (0 = reset); the only reset
- req  in  1  refund request; sampled only while ready=1
- amount  in  7  refund value 0..127, captured with req
- ready  out  1  high in IDLE; block accepts req
- eject  out  1  coin presented to mechanism
- eject_coin  out  2  denomination of presented coin: 0=1, 1=5, 2=10, 3=50; stable while eject=1
- eject_ack  in  1  mechanism took the presented coin; meaningful only while eject=1
- done  out  1  one-cycle pulse, refund finished
- short  out  7  unpaid remainder; updated when done is asserted, held until the next done
- refill  in  1  add coins to stock; honoured only in IDLE
- refill_sel  in  2  denomination to refill, same coding as eject_coin
- refill_cnt  in  8  number of coins added
- stock_empty  out  4  bit i high when the stock of denomination code i is 0

## Operation
- Stock is held in four 8-bit counters. refill adds refill_cnt to the selected counter, saturating at 255. refill outside IDLE is ignored.
- remain is a 7-bit working register.
- FSM states: IDLE, SELECT, EJECT, DONE.
- IDLE:
  - ready=1.
  - When req=1, remain<=amount and the FSM goes to SELECT. This applies for every amount, including 0.
  - If req and refill arrive in the same cycle, both are applied.
- SELECT:
  - Finds the largest denomination d with value(d) <= remain and stock(d) > 0.
  - If one is found: eject_coin<=d, go to EJECT.
  - If none is found (this includes remain=0): short<=remain, go to DONE.
  - The stock used for the choice is the registered value, so a refill applied in the IDLE cycle is visible.
- EJECT:
  - eject=1 and eject_coin is held.
  - On eject_ack=1: remain<=remain-value(d), stock(d)<=stock(d)-1, go to SELECT.
  - While eject_ack=0, the FSM stays in EJECT for as long as needed. There is no timeout.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - The subtraction never underflows, because value(d) <= remain is guaranteed by SELECT.
  - Stock never decrements below 0, because SELECT requires stock > 0.
- Greedy order is fixed: 50, then 10, then 5, then 1. Exact change is not searched beyond greedy with empty-skip.
- Reset asserted at any time aborts a payout in progress with no done pulse. Stock returns to the INIT_* values.
- Reset values:
  - state=IDLE, ready=1, eject=0, eject_coin=0, done=0, short=0, remain=0.
  - stock_empty reflects the INIT_* values (all 0 with the defaults).

## Timing
- ready, eject and done are decoded directly from the state register. eject_coin and short are registered. There are no combinational input-to-output paths.
- req sampled at edge E0 → SELECT. First eject is high after E1.
- eject_ack sampled at edge Ek → SELECT. The next coin's eject is high after Ek+1.
- Minimum throughput is 1 coin per 2 cycles; eject is low for at least one cycle between coins.
- Holding eject_ack=1 constantly gives the minimum 2-cycle rate.
- After the last ack, done is high 2 cycles later and ready is high the cycle after done.
- amount=0: done is high 2 cycles after req is sampled, with short=0.
- req while ready=0 is ignored; it is not queued.

## Test plan
- Default stock, amount=87, eject_ack tied high → eject_coin sequence 3,2,2,2,1,0,0 (7 coins, one every 2 cycles); done with short=0; stock becomes 3,7,9,18.
- Stock 50 refilled-from-zero test: reset with INIT_50=0, amount=60 → six coins of code 2, short=0, stock_empty[3]=1 throughout.
- INIT_1=0, amount=3 → no eject; done 2 cycles after req with short=3. Then amount=8 → one coin of code 1, then done with short=3.
- eject_ack delayed 5 cycles on the first coin of amount=15 → eject and eject_coin stay stable for all 5 cycles; total 2 coins (10, 5); done with short=0.
- Reset pulled low while in EJECT of the second coin of amount=87 → eject=0 and ready=1 immediately, no done pulse, stock back to INIT_*; a new req for amount=10 then pays one code-2 coin.
- In IDLE, refill of code 0 with refill_cnt=250 onto stock 20 → stock saturates at 255. refill attempted during EJECT → stock is unchanged.
